// File: rtl/servant_timer_pkg.sv
// Shared register map, ctrl bit positions and the byte-lane merge helper
// used by the servant machine timer.
package servant_timer_pkg;

    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;
    localparam logic [2:0] IDX_STATUS   = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_DIV_LSB = 8;

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge32(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/servant_timer_presc.sv
// Programmable prescaler: emits one tick every (div+1) enabled cycles.
module servant_timer_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [PRESC_W-1:0] i_div,
    input  logic               i_clr,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    assign o_tick = i_en & (r_cnt == i_div);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/servant_timer_wb.sv
// Wishbone machine timer: 64-bit mtime/mtimecmp, prescaled counting and a
// level timer interrupt for the SERV core.
module servant_timer_wb
    import servant_timer_pkg::*;
#(
    parameter logic RESET_EN = 1'b1,
    parameter int   PRESC_W  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    localparam logic [31:0] CTRL_MASK  = 32'h0000_0003 |
                                         (((32'd1 << PRESC_W) - 32'd1) << CTRL_DIV_LSB);
    localparam logic [31:0] CTRL_RESET = {31'b0, RESET_EN};

    logic [63:0] r_mtime;
    logic [63:0] r_cmp;
    logic [31:0] r_ctrl;
    logic [31:0] r_shadow;
    logic [31:0] r_rdt;
    logic        r_ack;
    logic        r_irq;

    logic               w_acc;
    logic               w_wr;
    logic               w_rd;
    logic               w_ge;
    logic               w_tick;
    logic               w_wr_lo;
    logic               w_wr_hi;
    logic               w_wr_ctrl;
    logic [31:0]        w_rd_val;
    logic [PRESC_W-1:0] w_div;

    // An access is taken on the edge that raises ack, so ack never repeats.
    assign w_acc     = i_wb_cyc & ~r_ack;
    assign w_wr      = w_acc & i_wb_we;
    assign w_rd      = w_acc & ~i_wb_we;
    assign w_ge      = (r_mtime >= r_cmp);
    assign w_div     = r_ctrl[CTRL_DIV_LSB +: PRESC_W];
    assign w_wr_lo   = w_wr && (i_wb_adr == IDX_MTIME_LO);
    assign w_wr_hi   = w_wr && (i_wb_adr == IDX_MTIME_HI);
    assign w_wr_ctrl = w_wr && (i_wb_adr == IDX_CTRL);

    servant_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (r_ctrl[CTRL_EN]),
        .i_div   (w_div),
        .i_clr   (w_wr_ctrl),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_rd_val = '0;
        case (i_wb_adr)
            IDX_MTIME_LO: w_rd_val = r_mtime[31:0];
            IDX_MTIME_HI: w_rd_val = r_shadow;
            IDX_CMP_LO:   w_rd_val = r_cmp[31:0];
            IDX_CMP_HI:   w_rd_val = r_cmp[63:32];
            IDX_CTRL:     w_rd_val = r_ctrl;
            IDX_STATUS:   w_rd_val = {31'b0, w_ge};
            default:      w_rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mtime  <= '0;
            r_cmp    <= CMP_RESET;
            r_ctrl   <= CTRL_RESET;
            r_shadow <= '0;
            r_rdt    <= '0;
            r_ack    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_irq <= r_ctrl[CTRL_IRQ_EN] & w_ge;

            // A bus write to either mtime half suppresses that edge's increment.
            if (w_wr_lo)
                r_mtime[31:0] <= merge32(r_mtime[31:0], i_wb_dat, i_wb_sel);
            if (w_wr_hi)
                r_mtime[63:32] <= merge32(r_mtime[63:32], i_wb_dat, i_wb_sel);
            if (!(w_wr_lo || w_wr_hi) && w_tick)
                r_mtime <= r_mtime + 64'd1;

            if (w_wr && (i_wb_adr == IDX_CMP_LO))
                r_cmp[31:0] <= merge32(r_cmp[31:0], i_wb_dat, i_wb_sel);
            if (w_wr && (i_wb_adr == IDX_CMP_HI))
                r_cmp[63:32] <= merge32(r_cmp[63:32], i_wb_dat, i_wb_sel);
            if (w_wr_ctrl)
                r_ctrl <= merge32(r_ctrl, i_wb_dat, i_wb_sel) & CTRL_MASK;

            if (w_rd) begin
                r_rdt <= w_rd_val;
                if (i_wb_adr == IDX_MTIME_LO)
                    r_shadow <= r_mtime[63:32];
            end
        end
    end

    assign o_wb_rdt    = r_rdt;
    assign o_wb_ack    = r_ack;
    assign o_timer_irq = r_irq;

endmodule

// File: tb/tb_servant_timer_wb.sv
// Scoreboard bench for servant_timer_wb against a behavioural timer model.
module tb_servant_timer_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [31:0] dat;
        logic [2:0]  idx;
    } exp_t;
    exp_t q[$];

    // Behavioural model state
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow;
    logic [7:0]  m_div, m_cnt;
    logic        m_en, m_irqen, m_ack, m_irq;

    servant_timer_wb #(.RESET_EN(1'b1), .PRESC_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb_adr    (adr),
        .i_wb_dat    (dat),
        .i_wb_sel    (sel),
        .i_wb_we     (we),
        .i_wb_cyc    (cyc),
        .o_wb_rdt    (rdt),
        .o_wb_ack    (ack),
        .o_timer_irq (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic        acc, ge, tick;
        logic [63:0] nt;
        logic [31:0] rv, cv;
        exp_t        e;
        if (!rst_n) begin
            m_mtime = 64'd0; m_cmp = {64{1'b1}}; m_shadow = 32'd0;
            m_div = 8'd0; m_cnt = 8'd0; m_en = 1'b1; m_irqen = 1'b0;
            m_ack = 1'b0; m_irq = 1'b0;
        end else begin
            acc  = cyc && !m_ack;
            ge   = (m_mtime >= m_cmp);
            tick = m_en && (m_cnt == m_div);
            m_irq = m_irqen && ge;
            m_ack = acc;
            if (acc && we && adr == 3'd4) m_cnt = 8'd0;
            else if (tick)                m_cnt = 8'd0;
            else if (m_en)                m_cnt = m_cnt + 8'd1;
            nt = tick ? m_mtime + 64'd1 : m_mtime;
            cv = {16'b0, m_div, 6'b0, m_irqen, m_en};
            if (acc) begin
                rv = 32'd0;
                if (!we) begin
                    case (adr)
                        3'd0: begin rv = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
                        3'd1: rv = m_shadow;
                        3'd2: rv = m_cmp[31:0];
                        3'd3: rv = m_cmp[63:32];
                        3'd4: rv = cv;
                        3'd5: rv = {31'b0, ge};
                        default: rv = 32'd0;
                    endcase
                end else begin
                    case (adr)
                        3'd0: nt = {m_mtime[63:32], bmerge(m_mtime[31:0], dat, sel)};
                        3'd1: nt = {bmerge(m_mtime[63:32], dat, sel), m_mtime[31:0]};
                        3'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], dat, sel);
                        3'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], dat, sel);
                        3'd4: begin
                            cv = bmerge(cv, dat, sel);
                            m_en = cv[0]; m_irqen = cv[1]; m_div = cv[15:8];
                        end
                        default: ;
                    endcase
                end
                e.we = we; e.dat = rv; e.idx = adr;
                q.push_back(e);
            end
            m_mtime = nt;
        end
    end

    // Monitor: per-cycle handshake/irq compare, and read data popped on each ack
    always @(negedge clk) begin : monitor
        exp_t e;
        checks++;
        if (ack !== m_ack) begin
            errors++;
            $display("FAIL ack_timing t=%0t got %b want %b", $time, ack, m_ack);
        end
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq t=%0t got %b want %b", $time, irq, m_irq);
        end
        if (ack === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack t=%0t", $time);
            end else begin
                e = q.pop_front();
                if (!e.we && rdt !== e.dat) begin
                    errors++;
                    $display("FAIL read_idx%0d t=%0t got %h want %h", e.idx, $time, rdt, e.dat);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic [31:0] r);
        bit got;
        got = 0;
        adr = i; dat = d; sel = s; we = w; cyc = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (ack) got = 1;
        end
        r = rdt;
        cyc = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout idx=%0d", i);
        end
    endtask

    task automatic wr(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb(i, d, s, 1'b1, r);
    endtask

    task automatic rd(input logic [2:0] i, output logic [31:0] r);
        wb(i, 32'd0, 4'hF, 1'b0, r);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [31:0] r, a, b;
        rst_n = 1'b0; cyc = 1'b0; adr = 3'd0; dat = 32'd0; sel = 4'h0; we = 1'b0;
        idle(3);
        checks++;
        if (rdt !== 32'd0) begin
            errors++; $display("FAIL reset_rdt got %h want 00000000", rdt);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) rd(3'(i), r);

        // div=3: mtime advances once per 4 cycles
        wr(3'd4, 32'h0000_0301, 4'hF);
        rd(3'd0, a);
        idle(40);
        rd(3'd0, b);
        checks++;
        if ((b - a) < 32'd9 || (b - a) > 32'd11) begin
            errors++; $display("FAIL presc_rate got %0d want 10+-1", b - a);
        end
        idle(2);
        wr(3'd4, 32'h0000_0301, 4'hF);
        for (int i = 0; i < 6; i++) rd(3'd0, r);

        // carry across the 32-bit boundary, read atomically via the shadow
        wr(3'd4, 32'h0000_0001, 4'hF);
        wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        wr(3'd1, 32'h0000_0000, 4'hF);
        idle(3);
        rd(3'd0, r);
        rd(3'd1, r);

        // interrupt compare
        wr(3'd4, 32'h0000_0000, 4'hF);
        wr(3'd2, 32'h0000_0020, 4'hF);
        wr(3'd3, 32'h0000_0000, 4'hF);
        wr(3'd1, 32'h0000_0000, 4'hF);
        wr(3'd0, 32'h0000_001E, 4'hF);
        wr(3'd4, 32'h0000_0003, 4'hF);
        idle(8);
        rd(3'd5, r);
        wr(3'd3, 32'h0000_0001, 4'hF);
        idle(3);
        wr(3'd3, 32'h0000_0000, 4'hF);
        wr(3'd4, 32'h0000_0001, 4'hF);
        idle(2);
        rd(3'd5, r);

        // byte-lane write
        wr(3'd2, 32'h1122_3344, 4'hF);
        wr(3'd2, 32'h00AB_0000, 4'b0100);
        rd(3'd2, r);
        checks++;
        if (r !== 32'h11AB_3344) begin
            errors++; $display("FAIL byte_write got %h want 11ab3344", r);
        end

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  ri;
            logic [31:0] rdd;
            ri  = 3'($urandom_range(0, 7));
            rdd = $urandom;
            if (ri == 3'd4) rdd = (rdd & 32'hFFFF_0302) | 32'h1;
            if ($urandom_range(0, 1) == 0) rd(ri, r);
            else wr(ri, rdd, 4'($urandom_range(0, 15)));
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                adr = 3'($urandom_range(0, 7)); we = 1'b0; cyc = 1'b1;
                idle($urandom_range(1, 6));
                cyc = 1'b0;
                idle(1);
            end
        end

        // reset lands on the edge that would have acknowledged the access
        wr(3'd2, 32'hDEAD_BEEF, 4'hF);
        wr(3'd4, 32'h0000_0503, 4'hF);
        adr = 3'd2; we = 1'b0; sel = 4'hF; cyc = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; cyc = 1'b0;
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack got %b want 0", ack);
        end
        for (int i = 0; i < 6; i++) rd(3'(i), r);
        rd(3'd4, r);
        checks++;
        if (r !== 32'h0000_0001) begin
            errors++; $display("FAIL reset_ctrl got %h want 00000001", r);
        end

        idle(4);
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
